// File: rtl/jk_bank_seq_if.sv
// Command handshake bundle for jk_bank_seq: valid/ready plus op, step count and data.
interface jk_bank_seq_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [7:0]       cmd_len;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_seq.sv
// Command-driven sequencer that steps a bank of JK cells through clear/load/count/shift/toggle.
//  state  | meaning
//  S_IDLE | waiting for a command, cmd_ready high
//  S_RUN  | J/K applied to the bank, one step per clock
//  S_DONE | completion cycle, done pulses
//  S_ERR  | illegal op was accepted, err pulses
module jk_bank_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_bank_seq_if.slave     cmd,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_UP     = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_SHL    = 3'd5;
    localparam logic [2:0] OP_TOGGLE = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    state_t           state, state_nx;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [7:0]       cnt_r, cnt_nx, eff_len;
    logic [WIDTH-1:0] j_int, k_int, q_nx, shl_t;
    logic             accept, chain;

    assign accept = cmd.cmd_valid && (state == S_IDLE);
    // Single-step ops ignore cmd_len.
    assign eff_len = (cmd.cmd_op == OP_CLEAR || cmd.cmd_op == OP_LOAD) ? 8'd1 : cmd.cmd_len;
    assign shl_t = {q[WIDTH-2:0], data_r[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_r;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nx = eff_len;
                    if (cmd.cmd_op == OP_ILLEGAL) state_nx = S_ERR;
                    else if (eff_len == 8'd0)     state_nx = S_DONE;
                    else                          state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_r == 8'd1) state_nx = S_DONE;
                else               cnt_nx   = cnt_r - 8'd1;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= OP_HOLD;
            data_r <= '0;
            cnt_r  <= '0;
            q      <= '0;
        end else begin
            cnt_r <= cnt_nx;
            if (accept) begin
                op_r   <= cmd.cmd_op;
                data_r <= cmd.cmd_data;
            end
            if (state == S_RUN) q <= q_nx;
        end
    end

    // Counting uses the ripple-carry JK form: a cell toggles when all lower cells are 1 (up) or 0 (down).
    always_comb begin
        j_int = '0;
        k_int = '0;
        chain = 1'b1;
        if (state == S_RUN) begin
            case (op_r)
                OP_CLEAR: k_int = '1;
                OP_LOAD: begin
                    j_int = data_r;
                    k_int = ~data_r;
                end
                OP_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j_int[i] = chain;
                        k_int[i] = chain;
                        chain    = chain & q[i];
                    end
                end
                OP_DOWN: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j_int[i] = chain;
                        k_int[i] = chain;
                        chain    = chain & ~q[i];
                    end
                end
                OP_SHL: begin
                    j_int = shl_t;
                    k_int = ~shl_t;
                end
                OP_TOGGLE: begin
                    j_int = data_r;
                    k_int = data_r;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        q_nx = q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_int[i], k_int[i]})
                2'b01:   q_nx[i] = 1'b0;
                2'b10:   q_nx[i] = 1'b1;
                2'b11:   q_nx[i] = ~q[i];
                default: q_nx[i] = q[i];
            endcase
        end
    end

    assign cmd.cmd_ready = (state == S_IDLE);
    assign busy  = (state == S_RUN) || (state == S_DONE);
    assign done  = (state == S_DONE);
    assign err   = (state == S_ERR);
    assign qb    = ~q;
    assign j_out = j_int;
    assign k_out = k_int;
endmodule

// File: tb/tb_jk_bank_seq.sv
// Directed self-checking bench for jk_bank_seq with WIDTH=4.
module tb_jk_bank_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] j_out, k_out, q, qb;
    logic busy, done, err;

    int total = 0;
    int pass_cnt = 0;
    int done_seen = 0;
    int qb_bad = 0;

    jk_bank_seq_if #(.WIDTH(W)) cmd_if ();

    jk_bank_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd_if),
        .j_out (j_out),
        .k_out (k_out),
        .q     (q),
        .qb    (qb),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
        if (qb !== ~q) qb_bad++;
    end

    // Drives one command; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] len, input logic [W-1:0] data);
        int t = 0;
        @(negedge clk);
        while (!cmd_if.cmd_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 300) $display("FAIL issue_timeout: cmd_ready stayed low, op=%0d", op);
        else pass_cnt++;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_len   = len;
        cmd_if.cmd_data  = data;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 4'b1111;
    endtask

    // Counts negedges until cmd_ready returns, plus done/err pulses seen meanwhile.
    task automatic wait_idle(output int cyc, output int ndone, output int nerr);
        cyc = 0; ndone = 0; nerr = 0;
        while (!cmd_if.cmd_ready && cyc < 300) begin
            if (done) ndone++;
            if (err)  nerr++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) begin
            total++;
            $display("FAIL idle_timeout: cycles=%0d required<300", cyc);
        end
    endtask

    task automatic test_reset();
        int d0;
        #2;
        total++;
        if ({q, qb, j_out, k_out} !== {4'h0, 4'hF, 4'h0, 4'h0} || {busy, done, err, cmd_if.cmd_ready} !== 4'b0001)
            $display("FAIL reset_values: q=%h qb=%h j=%h k=%h bde_r=%b required 0 f 0 0 0001",
                     q, qb, j_out, k_out, {busy, done, err, cmd_if.cmd_ready});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        issue(3'd3, 8'd10, 4'h0);
        repeat (3) @(negedge clk);
        total++;
        if (q !== 4'd3 || busy !== 1'b1) $display("FAIL mid_run: q=%h busy=%b required 3 1", q, busy);
        else pass_cnt++;
        d0 = done_seen;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (q !== 4'h0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || j_out !== 4'h0 || k_out !== 4'h0)
            $display("FAIL reset_abort: q=%h busy=%b ready=%b j=%h k=%h required 0 0 1 0 0",
                     q, busy, cmd_if.cmd_ready, j_out, k_out);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (done_seen !== d0 || q !== 4'h0)
            $display("FAIL reset_no_done: done pulses=%0d q=%h required 0 0", done_seen - d0, q);
        else pass_cnt++;
    endtask

    task automatic test_load_count();
        int cyc, nd, ne;
        issue(3'd2, 8'd0, 4'b1010);
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'b1010 || cyc !== 2 || nd !== 1)
            $display("FAIL load: q=%b cyc=%0d done=%0d required 1010 2 1", q, cyc, nd);
        else pass_cnt++;
        issue(3'd3, 8'd7, 4'h0);
        repeat (6) @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) $display("FAIL up_running: done=%b busy=%b required 0 1", done, busy);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || q !== 4'b0001) $display("FAIL up_done: done=%b q=%b required 1 0001", done, q);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || q !== 4'b0001)
            $display("FAIL up_after: done=%b ready=%b q=%b required 0 1 0001", done, cmd_if.cmd_ready, q);
        else pass_cnt++;
    endtask

    task automatic test_clear_down_toggle();
        int cyc, nd, ne;
        issue(3'd1, 8'd9, 4'h0);
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'h0 || cyc !== 2 || nd !== 1)
            $display("FAIL clear: q=%h cyc=%0d done=%0d required 0 2 1", q, cyc, nd);
        else pass_cnt++;
        issue(3'd4, 8'd1, 4'h0);
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'hF || cyc !== 2) $display("FAIL down_wrap: q=%h cyc=%0d required f 2", q, cyc);
        else pass_cnt++;
        issue(3'd6, 8'd3, 4'b0101);
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'b1010 || cyc !== 4 || nd !== 1)
            $display("FAIL toggle: q=%b cyc=%0d done=%0d required 1010 4 1", q, cyc, nd);
        else pass_cnt++;
        issue(3'd4, 8'd3, 4'h0);
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'b0111) $display("FAIL down_steps: q=%b required 0111", q);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        int cyc, nd, ne;
        logic [W-1:0] exp_q [4];
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0011; exp_q[2] = 4'b0111; exp_q[3] = 4'b1111;
        issue(3'd2, 8'd0, 4'b0000);
        wait_idle(cyc, nd, ne);
        issue(3'd5, 8'd4, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (j_out !== ~k_out || j_out !== {q[2:0], 1'b1})
                $display("FAIL shift_jk%0d: j=%b k=%b q=%b", i, j_out, k_out, q);
            else pass_cnt++;
            @(negedge clk);
            total++;
            if (q !== exp_q[i]) $display("FAIL shift_q%0d: q=%b required %b", i, q, exp_q[i]);
            else pass_cnt++;
        end
        total++;
        if (done !== 1'b1 || j_out !== 4'h0 || k_out !== 4'h0)
            $display("FAIL shift_done: done=%b j=%b k=%b required 1 0000 0000", done, j_out, k_out);
        else pass_cnt++;
        wait_idle(cyc, nd, ne);
    endtask

    task automatic test_zero_err();
        int cyc, nd, ne;
        issue(3'd0, 8'd0, 4'h0);
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || q !== 4'hF || cmd_if.cmd_ready !== 1'b0)
            $display("FAIL zero_len: done=%b busy=%b q=%h ready=%b required 1 1 f 0", done, busy, q, cmd_if.cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (cmd_if.cmd_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL zero_ready: ready=%b done=%b required 1 0", cmd_if.cmd_ready, done);
        else pass_cnt++;
        issue(3'd7, 8'd5, 4'h3);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b0)
            $display("FAIL illegal: err=%b done=%b busy=%b ready=%b required 1 0 0 0", err, done, busy, cmd_if.cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (err !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || q !== 4'hF || done !== 1'b0)
            $display("FAIL illegal_after: err=%b ready=%b q=%h done=%b required 0 1 f 0", err, cmd_if.cmd_ready, q, done);
        else pass_cnt++;
        issue(3'd0, 8'd2, 4'h0);
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'hF || cyc !== 3 || nd !== 1 || ne !== 0)
            $display("FAIL hold: q=%h cyc=%0d done=%0d err=%0d required f 3 1 0", q, cyc, nd, ne);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc, nd, ne, acc, first, second;
        issue(3'd1, 8'd0, 4'h0);
        wait_idle(cyc, nd, ne);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd6;
        cmd_if.cmd_len   = 8'd3;
        cmd_if.cmd_data  = 4'b0001;
        acc = 0; first = -1; second = -1;
        for (int k = 0; k < 40 && acc < 2; k++) begin
            if (cmd_if.cmd_ready) begin
                if (acc == 0) first = k;
                else begin
                    second = k;
                    cmd_if.cmd_data = 4'b0110;
                    cmd_if.cmd_len  = 8'd1;
                end
                acc++;
            end else begin
                cmd_if.cmd_data = cmd_if.cmd_data + 4'd3;
            end
            @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b0;
        total++;
        if (acc !== 2 || second - first !== 5)
            $display("FAIL b2b_spacing: accepts=%0d spacing=%0d required 2 5", acc, second - first);
        else pass_cnt++;
        wait_idle(cyc, nd, ne);
        total++;
        if (q !== 4'b0111) $display("FAIL b2b_result: q=%b required 0111", q);
        else pass_cnt++;
    endtask

    task automatic test_qb();
        total++;
        if (qb_bad !== 0) $display("FAIL qb_inverse: bad cycles=%0d required 0", qb_bad);
        else pass_cnt++;
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_len   = 8'd0;
        cmd_if.cmd_data  = 4'h0;
        test_reset();
        test_load_count();
        test_clear_down_toggle();
        test_shift();
        test_zero_err();
        test_back_to_back();
        test_qb();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
